// File: rtl/egg_timer_ctrl_if.sv
// egg_timer_ctrl_if
//  Bundles the egg-timer control pulses and the display/status outputs.
//  master: drives the one-clk pulses (debounce / clock-divider side), reads status.
//  slave : the countdown sequencer; reads pulses, drives digits and status.
//  Signals:
//   tick_1hz, start, clear, min_inc, sec_inc   one-clk pulses into the sequencer
//   sec_ones, sec_tens, min_ones, min_tens     BCD cook-time digits
//   state    00 SET, 01 RUN, 10 PAUSE, 11 ALARM
//   running, done, alarm_led, firm             status flags
interface egg_timer_ctrl_if;
  logic       tick_1hz;
  logic       start;
  logic       clear;
  logic       min_inc;
  logic       sec_inc;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [1:0] state;
  logic       running;
  logic       done;
  logic       alarm_led;
  logic       firm;

  modport master (
    output tick_1hz, start, clear, min_inc, sec_inc,
    input  sec_ones, sec_tens, min_ones, min_tens, state, running, done, alarm_led, firm
  );

  modport slave (
    input  tick_1hz, start, clear, min_inc, sec_inc,
    output sec_ones, sec_tens, min_ones, min_tens, state, running, done, alarm_led, firm
  );
endinterface

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl
//  Countdown sequencer for the egg timer. Holds MM:SS as four BCD digits, lets the
//  user set them in SET, counts down once per tick in RUN, freezes in PAUSE and
//  signals a timed alarm at 00:00.
//  Ports:
//   clk      system clock, all state on rising edge
//   reset_n  asynchronous active-low reset
//   bus      egg_timer_ctrl_if.slave: pulse inputs, BCD digits and status outputs
//  Pulse priority within one cycle: clear > start > tick_1hz > min_inc/sec_inc.
module egg_timer_ctrl #(
  parameter int MAX_MIN     = 99,
  parameter int ALARM_TICKS = 10,
  parameter int FIRM_MIN    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  egg_timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SET   = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_t;

  localparam int          CW      = $clog2(ALARM_TICKS + 1);
  localparam logic [6:0]  MAX_V   = 7'(MAX_MIN);
  localparam logic [6:0]  FIRM_V  = 7'(FIRM_MIN);
  localparam logic [CW-1:0] ALARM_V = CW'(ALARM_TICKS);

  state_t        state_reg, state_next;
  logic [3:0]    so_reg, so_next;
  logic [3:0]    st_reg, st_next;
  logic [3:0]    mo_reg, mo_next;
  logic [3:0]    mt_reg, mt_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          led_reg, led_next;
  logic          done_reg, done_next;

  logic [6:0]    min_val;
  logic          time_zero;
  logic          dec_zero;
  logic [CW-1:0] cnt_inc;

  assign min_val   = 7'(mt_reg) * 7'd10 + 7'(mo_reg);
  assign time_zero = ({mt_reg, mo_reg, st_reg, so_reg} == 16'h0000);
  // The decrement lands on 00:00 exactly when the current time is 00:01.
  assign dec_zero  = ({mt_reg, mo_reg, st_reg, so_reg} == 16'h0001);
  assign cnt_inc   = cnt_reg + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_SET;
      so_reg    <= 4'd0;
      st_reg    <= 4'd0;
      mo_reg    <= 4'd0;
      mt_reg    <= 4'd0;
      cnt_reg   <= '0;
      led_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      so_reg    <= so_next;
      st_reg    <= st_next;
      mo_reg    <= mo_next;
      mt_reg    <= mt_next;
      cnt_reg   <= cnt_next;
      led_reg   <= led_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    so_next    = so_reg;
    st_next    = st_reg;
    mo_next    = mo_reg;
    mt_next    = mt_reg;
    cnt_next   = cnt_reg;
    led_next   = led_reg;
    done_next  = 1'b0;

    case (state_reg)
      ST_SET: begin
        if (bus.clear) begin
          {mt_next, mo_next, st_next, so_next} = 16'h0000;
        end else if (bus.start) begin
          if (!time_zero) state_next = ST_RUN;
        end else if (!bus.tick_1hz) begin
          // A tick in SET has no effect but still shadows the inc pulses.
          if (bus.sec_inc) begin
            if ({st_reg, so_reg} == 8'h59) begin
              st_next = 4'd0;
              so_next = 4'd0;
            end else if (so_reg == 4'd9) begin
              so_next = 4'd0;
              st_next = st_reg + 4'd1;
            end else begin
              so_next = so_reg + 4'd1;
            end
          end
          if (bus.min_inc) begin
            if (min_val >= MAX_V) begin
              mt_next = 4'd0;
              mo_next = 4'd0;
            end else if (mo_reg == 4'd9) begin
              mo_next = 4'd0;
              mt_next = mt_reg + 4'd1;
            end else begin
              mo_next = mo_reg + 4'd1;
            end
          end
        end
      end

      ST_RUN: begin
        if (bus.clear) begin
          state_next = ST_SET;
          {mt_next, mo_next, st_next, so_next} = 16'h0000;
        end else if (bus.start) begin
          state_next = ST_PAUSE;
        end else if (bus.tick_1hz && !time_zero) begin
          // BCD borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
          if (so_reg != 4'd0) begin
            so_next = so_reg - 4'd1;
          end else begin
            so_next = 4'd9;
            if (st_reg != 4'd0) begin
              st_next = st_reg - 4'd1;
            end else begin
              st_next = 4'd5;
              if (mo_reg != 4'd0) begin
                mo_next = mo_reg - 4'd1;
              end else begin
                mo_next = 4'd9;
                mt_next = mt_reg - 4'd1;
              end
            end
          end
          if (dec_zero) begin
            state_next = ST_ALARM;
            done_next  = 1'b1;
            cnt_next   = '0;
            led_next   = 1'b0;
          end
        end
      end

      ST_PAUSE: begin
        if (bus.clear) begin
          state_next = ST_SET;
          {mt_next, mo_next, st_next, so_next} = 16'h0000;
        end else if (bus.start) begin
          state_next = ST_RUN;
        end
      end

      ST_ALARM: begin
        if (bus.clear || bus.start) begin
          state_next = ST_SET;
          cnt_next   = '0;
          led_next   = 1'b0;
        end else if (bus.tick_1hz) begin
          if (cnt_inc == ALARM_V) begin
            state_next = ST_SET;
            cnt_next   = '0;
            led_next   = 1'b0;
          end else begin
            cnt_next = cnt_inc;
            led_next = ~led_reg;
          end
        end
      end

      default: begin
        state_next = ST_SET;
      end
    endcase
  end

  assign bus.sec_ones  = so_reg;
  assign bus.sec_tens  = st_reg;
  assign bus.min_ones  = mo_reg;
  assign bus.min_tens  = mt_reg;
  assign bus.state     = state_reg;
  assign bus.running   = (state_reg == ST_RUN);
  assign bus.done      = done_reg;
  assign bus.alarm_led = led_reg;
  assign bus.firm      = (min_val >= FIRM_V);

endmodule
